midi_note_rx: RTL and testbench
===============================

MIDI_NOTE_RX -- requirements
Module: midi_note_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1600, clk cycles per MIDI bit (50 MHz / 31250 baud).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port midiRx  input  1  asynchronous MIDI serial line, idle high.
REQ-005 SHALL have port resetNoteForMem  input  1  consumer acknowledge; clears noteForMem.
REQ-006 SHALL have port midiNotes  output  16  last note word: {noteOn, note[6:0], 1'b0, velocity[6:0]}.
REQ-007 SHALL have port midiInterrupt  output  1  one-cycle pulse per new note word.
REQ-008 SHALL have port noteForMem  output  1  held high while an unacknowledged note word is pending.
REQ-009 SHALL have port overrun  output  1  sticky; a note word arrived while noteForMem was high.
REQ-010 SHALL have port frameErr  output  1  sticky; a byte had a low stop bit.

Function
REQ-011 SHALL pass midiRx through a 2-flop synchronizer before any use (2-cycle input latency).
REQ-012 SHALL run receiver FSM states IDLE, START, DATA, STOP with a bit counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-013 IDLE->START on synchronized falling edge; START samples at CLKS_PER_BIT/2; sample high -> IDLE (glitch), low -> DATA.
REQ-014 DATA SHALL sample 8 bits LSB first, each CLKS_PER_BIT after the previous sample, then go to STOP.
REQ-015 STOP samples one bit period later: high -> byte valid for one cycle; low -> set frameErr, discard byte; both -> IDLE.
REQ-016 Parser SHALL hold running status (NONE, NOTE_ON, NOTE_OFF) and data state (WAIT_NOTE, WAIT_VEL).
REQ-017 Status 0x90-0x9F -> NOTE_ON; 0x80-0x8F -> NOTE_OFF; either sets WAIT_NOTE; channel nibble ignored.
REQ-018 Status 0xA0-0xF7 -> running status NONE, WAIT_NOTE; data bytes then discarded until next note status.
REQ-019 Status 0xF8-0xFF (real-time) SHALL be ignored with no change to parser state.
REQ-020 Data byte in WAIT_NOTE with status not NONE -> latch note, go WAIT_VEL; in WAIT_VEL -> emit word, return WAIT_NOTE (running status kept).
REQ-021 Emitted word: noteOn = 1 only for NOTE_ON with velocity != 0; NOTE_ON velocity 0 emits noteOn = 0, velocity 0.
REQ-022 On emit, midiNotes SHALL update and midiInterrupt pulse in the cycle after the velocity byte-valid cycle; noteForMem high from that same cycle.
REQ-023 noteForMem SHALL clear the cycle after resetNoteForMem is sampled high; ack while low has no effect.
REQ-024 Emit and resetNoteForMem in the same cycle: emit wins, noteForMem stays high, overrun not set.
REQ-025 Emit while noteForMem high (no same-cycle ack): midiNotes overwritten, overrun set, noteForMem stays high.
REQ-026 midiNotes SHALL hold its value between emits.

Reset
REQ-027 Reset SHALL force receiver IDLE, counters 0, parser NONE/WAIT_NOTE, midiNotes 16'h0000, midiInterrupt 0, noteForMem 0, overrun 0, frameErr 0, synchronizer flops 1.
REQ-028 Reset mid-byte SHALL abandon the byte; reception restarts only on a falling edge after reset deasserts.
REQ-029 overrun and frameErr SHALL clear only on reset.

Verification (CLKS_PER_BIT = 8)
REQ-030 Bytes 0x90,0x3C,0x64 -> single midiInterrupt pulse, midiNotes = 16'hBC64, noteForMem = 1.
REQ-031 Then 0x3E,0x00 (running status) -> midiNotes = 16'h3E00, overrun = 1; pulse resetNoteForMem -> noteForMem = 0 next cycle.
REQ-032 Bytes 0x80,0x40,0xF8,0x10 -> midiNotes = 16'h4010, exactly one pulse, real-time byte ignored.
REQ-033 Bytes 0xB0,0x07,0x7F -> no pulse, midiNotes unchanged; byte 0x45 sent with stop bit low -> frameErr = 1, no parser change.
REQ-034 3-cycle low glitch on idle midiRx -> no byte, no flags; reset asserted mid-data-bit -> all outputs zero, next clean 0x90,0x30,0x01 -> 16'hB001.
REQ-035 Emit coincident with resetNoteForMem -> noteForMem stays 1, overrun stays 0.

Source files
------------

// File: rtl/midi_note_rx.sv
// MIDI serial receiver with a note-on/note-off parser.
// Emits {noteOn, note, 1'b0, velocity} words and a pending flag that the consumer acknowledges.
module midi_note_rx #(
    parameter int unsigned CLKS_PER_BIT = 1600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        midiRx,
    input  logic        resetNoteForMem,
    output logic [15:0] midiNotes,
    output logic        midiInterrupt,
    output logic        noteForMem,
    output logic        overrun,
    output logic        frameErr
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;
    typedef enum logic [1:0] {RsNone, RsNoteOn, RsNoteOff} run_status_e;

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        sync1_q, sync2_q, rx_last_q;
    logic        fall, byte_valid, stop_err;

    run_status_e rs_q;
    logic        wait_vel_q;
    logic [6:0]  note_q;
    logic        is_rt, emit;
    logic [15:0] word;

    // rx_last_q only feeds the edge detector; all sampling uses sync2_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_last_q <= 1'b1;
        end else begin
            sync1_q   <= midiRx;
            sync2_q   <= sync1_q;
            rx_last_q <= sync2_q;
        end
    end

    assign fall = rx_last_q & ~sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    shreg_d   = {sync2_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        if (state_q == StStop && cnt_q == CntLast) begin
            byte_valid = sync2_q;
            stop_err   = ~sync2_q;
        end
    end

    always_comb begin
        is_rt = (shreg_q[7:3] == 5'b11111);
        emit  = byte_valid && !shreg_q[7] && (rs_q != RsNone) && wait_vel_q;
        word  = {(rs_q == RsNoteOn) && (shreg_q[6:0] != 7'd0), note_q, 1'b0, shreg_q[6:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_q       <= RsNone;
            wait_vel_q <= 1'b0;
            note_q     <= '0;
        end else if (byte_valid) begin
            if (shreg_q[7]) begin
                if (!is_rt) begin
                    wait_vel_q <= 1'b0;
                    if (shreg_q[7:4] == 4'h9)      rs_q <= RsNoteOn;
                    else if (shreg_q[7:4] == 4'h8) rs_q <= RsNoteOff;
                    else                           rs_q <= RsNone;
                end
            end else if (rs_q != RsNone) begin
                if (!wait_vel_q) begin
                    note_q     <= shreg_q[6:0];
                    wait_vel_q <= 1'b1;
                end else begin
                    wait_vel_q <= 1'b0;
                end
            end
        end
    end

    // A same-cycle acknowledge loses to a new word and does not count as overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            midiNotes     <= 16'h0000;
            midiInterrupt <= 1'b0;
            noteForMem    <= 1'b0;
            overrun       <= 1'b0;
            frameErr      <= 1'b0;
        end else begin
            midiInterrupt <= emit;
            if (emit) midiNotes <= word;
            if (emit)                 noteForMem <= 1'b1;
            else if (resetNoteForMem) noteForMem <= 1'b0;
            if (emit && noteForMem && !resetNoteForMem) overrun <= 1'b1;
            if (stop_err) frameErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_midi_note_rx.sv
// Bench for midi_note_rx: directed scenarios followed by a random byte stream
// checked against a message-level note model.
module tb_midi_note_rx;

    localparam int unsigned CPB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        midiRx = 1'b1;
    logic        resetNoteForMem = 1'b0;
    logic [15:0] midiNotes;
    logic        midiInterrupt, noteForMem, overrun, frameErr;

    int n_cmp = 0;
    int n_err = 0;
    int irq_n = 0;
    logic [15:0] got[$];

    always #5 clk = ~clk;

    midi_note_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .reset          (reset),
        .midiRx         (midiRx),
        .resetNoteForMem(resetNoteForMem),
        .midiNotes      (midiNotes),
        .midiInterrupt  (midiInterrupt),
        .noteForMem     (noteForMem),
        .overrun        (overrun),
        .frameErr       (frameErr)
    );

    always @(posedge clk) begin
        if (!reset && midiInterrupt) begin
            irq_n <= irq_n + 1;
            got.push_back(midiNotes);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        midiRx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            midiRx = b[i];
            repeat (CPB) @(posedge clk);
        end
        midiRx = stop;
        repeat (CPB) @(posedge clk);
        midiRx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        midiRx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_notes"}, {16'h0, midiNotes}, 32'h0);
        chk({tag, "_irq"}, {31'h0, midiInterrupt}, 32'h0);
        chk({tag, "_nfm"}, {31'h0, noteForMem}, 32'h0);
        chk({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
        chk({tag, "_ferr"}, {31'h0, frameErr}, 32'h0);
    endtask

    initial begin
        int base;
        int rs;
        logic wv;
        logic [7:0] nt;
        logic [7:0] b;
        logic [15:0] exp_q[$];
        bit found;

        // Reset state, sampled while reset is still asserted
        repeat (4) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Note on with velocity
        base = irq_n;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
        @(negedge clk);
        chk("on_pulses", irq_n - base, 1);
        chk("on_word", {16'h0, midiNotes}, 32'hBC64);
        chk("on_word_at_pulse", {16'h0, got[$]}, 32'hBC64);
        chk("on_nfm", {31'h0, noteForMem}, 1);
        chk("on_ovr", {31'h0, overrun}, 0);

        // Running status, velocity 0, overrun
        send_byte(8'h3E, 1'b1); send_byte(8'h00, 1'b1);
        @(negedge clk);
        chk("rs_pulses", irq_n - base, 2);
        chk("rs_word", {16'h0, midiNotes}, 32'h3E00);
        chk("rs_ovr", {31'h0, overrun}, 1);
        resetNoteForMem = 1'b1;
        @(negedge clk);
        resetNoteForMem = 1'b0;
        chk("ack_nfm", {31'h0, noteForMem}, 0);

        // Note off with an interleaved real-time byte
        base = irq_n;
        send_byte(8'h80, 1'b1); send_byte(8'h40, 1'b1);
        send_byte(8'hF8, 1'b1); send_byte(8'h10, 1'b1);
        @(negedge clk);
        chk("off_pulses", irq_n - base, 1);
        chk("off_word", {16'h0, midiNotes}, 32'h4010);
        chk("off_nfm", {31'h0, noteForMem}, 1);
        chk("ovr_sticky", {31'h0, overrun}, 1);

        // Controller message is discarded; framing error leaves parser alone
        base = irq_n;
        send_byte(8'hB0, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h7F, 1'b1);
        @(negedge clk);
        chk("cc_pulses", irq_n - base, 0);
        chk("cc_word", {16'h0, midiNotes}, 32'h4010);
        chk("pre_ferr", {31'h0, frameErr}, 0);
        send_byte(8'h45, 1'b0);
        @(negedge clk);
        chk("ferr_set", {31'h0, frameErr}, 1);
        chk("ferr_pulses", irq_n - base, 0);
        send_byte(8'h90, 1'b1); send_byte(8'h11, 1'b1);
        send_byte(8'h45, 1'b0);
        send_byte(8'h22, 1'b1);
        @(negedge clk);
        chk("ferr_skip_pulses", irq_n - base, 1);
        chk("ferr_skip_word", {16'h0, midiNotes}, 32'h9122);

        // Reset in the middle of a data bit
        @(posedge clk);
        midiRx = 1'b0;
        repeat (CPB + CPB / 2 + 3 * CPB) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        midiRx = 1'b1;
        repeat (4) @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Parser restarts with no running status
        base = irq_n;
        send_byte(8'h30, 1'b1); send_byte(8'h01, 1'b1);
        @(negedge clk);
        chk("nostatus_pulses", irq_n - base, 0);

        // Short low glitch on an idle line
        @(posedge clk);
        midiRx = 1'b0;
        repeat (3) @(posedge clk);
        midiRx = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        @(negedge clk);
        chk("glitch_pulses", irq_n - base, 0);
        chk("glitch_ferr", {31'h0, frameErr}, 0);
        chk("glitch_nfm", {31'h0, noteForMem}, 0);

        send_byte(8'h90, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'h01, 1'b1);
        @(negedge clk);
        chk("post_reset_word", {16'h0, midiNotes}, 32'hB001);
        chk("post_reset_pulses", irq_n - base, 1);

        // Acknowledge in the same cycle as a new word
        send_byte(8'h31, 1'b1);
        found = 1'b0;
        fork
            send_byte(8'h02, 1'b1);
            begin
                for (int i = 0; i < 40 * CPB && !found; i++) begin
                    @(negedge clk);
                    if (dut.byte_valid) begin
                        found = 1'b1;
                        resetNoteForMem = 1'b1;
                        @(negedge clk);
                        resetNoteForMem = 1'b0;
                    end
                end
            end
        join
        @(negedge clk);
        chk("coinc_found", {31'h0, found}, 1);
        chk("coinc_word", {16'h0, midiNotes}, 32'hB102);
        chk("coinc_nfm", {31'h0, noteForMem}, 1);
        chk("coinc_ovr", {31'h0, overrun}, 0);

        // Random byte stream against a message-level model
        do_reset();
        base = irq_n;
        rs = 0;
        wv = 1'b0;
        nt = 8'h00;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0:       b = {4'h9, 4'($urandom_range(0, 15))};
                1:       b = {4'h8, 4'($urandom_range(0, 15))};
                2:       b = 8'($urandom_range(8'hA0, 8'hF7));
                3:       b = 8'($urandom_range(8'hF8, 8'hFF));
                4:       b = 8'h00;
                default: b = 8'($urandom_range(0, 127));
            endcase
            if (b >= 8'hF8) begin
                // real-time: no effect
            end else if (b >= 8'h80) begin
                wv = 1'b0;
                rs = (b[7:4] == 4'h9) ? 1 : (b[7:4] == 4'h8) ? 2 : 0;
            end else if (rs != 0) begin
                if (!wv) begin
                    nt = b;
                    wv = 1'b1;
                end else begin
                    exp_q.push_back({(rs == 1) && (b != 8'h00), nt[6:0], 1'b0, b[6:0]});
                    wv = 1'b0;
                end
            end
            send_byte(b, 1'b1);
        end
        @(negedge clk);
        chk("rand_count", irq_n - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            chk($sformatf("rand_word%0d", i), {16'h0, got[base + i]}, {16'h0, exp_q[i]});
        chk("rand_nfm", {31'h0, noteForMem}, {31'h0, exp_q.size() > 0});
        chk("rand_ovr", {31'h0, overrun}, {31'h0, exp_q.size() > 1});
        chk("rand_ferr", {31'h0, frameErr}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
